// File: rtl/picorv32_sdram32_pkg.sv
// Shared definitions for the picorv32 to 16-bit SDRAM controller bridge:
// FSM encoding, half selectors, op codes and the per-half op planner.
package picorv32_sdram32_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PLAN  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;

    // Op codes double as the controller rwn level.
    localparam logic OP_RD = 1'b1;
    localparam logic OP_WR = 1'b0;

    // Returns {need_wr, need_rd} for one halfword. Ops are executed in
    // mask order {wr_hi, rd_hi, wr_lo, rd_lo}, lowest set bit first, so a
    // read always precedes the write that merges into it.
    function automatic logic [1:0] half_ops(input logic is_read,
                                            input logic [1:0] strb,
                                            input logic rmw_en);
        logic [1:0] ops;
        ops = 2'b00;
        if (is_read) begin
            ops = 2'b01;
        end else begin
            case (strb)
                2'b00:   ops = 2'b00;
                2'b11:   ops = 2'b10;
                default: ops = rmw_en ? 2'b11 : 2'b10;
            endcase
        end
        return ops;
    endfunction

endpackage

// File: rtl/picorv32_sdram32_byte_merge.sv
// Combinational halfword byte merge: each byte comes from new_data_i when
// its strobe is set, otherwise from old_data_i.
module picorv32_sdram32_byte_merge (
    input  logic [15:0] old_data_i,
    input  logic [15:0] new_data_i,
    input  logic [1:0]  strb_i,
    output logic [15:0] merged_o
);

    // Byte-wise select between the read-back data and the new write data.
    always_comb begin
        merged_o[7:0]  = strb_i[0] ? new_data_i[7:0]  : old_data_i[7:0];
        merged_o[15:8] = strb_i[1] ? new_data_i[15:8] : old_data_i[15:8];
    end

endmodule

// File: rtl/picorv32_sdram32.sv
// Bridge from the picorv32 native memory bus to a 16-bit SDRAM controller.
// Each 32-bit access becomes one to four halfword commands; partial-halfword
// writes use read-modify-write when RMW_EN is set.
//
// Handshakes: the CPU side is accepted in IDLE when mem_valid is high and
// mem_ready is low; mem_ready is a single-cycle completion pulse. On the
// controller side ctl_adv is raised only when the controller is idle, its
// address/rwn/wdata are held stable until ctl_ack, and the op is complete
// once the controller is idle again with ctl_adv low.
module picorv32_sdram32
    import picorv32_sdram32_pkg::*;
#(
    parameter int WORD_AW = 24,
    parameter int CTL_AW  = 27,
    parameter bit RMW_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_rdata,
    output logic              busy,
    output logic [CTL_AW-1:0] ctl_addr,
    output logic              ctl_adv,
    output logic              ctl_rwn,
    output logic [15:0]       ctl_wdata,
    input  logic              ctl_ack,
    input  logic              ctl_data_valid,
    input  logic [15:0]       ctl_rdata,
    input  logic              ctl_busy,
    input  logic              ctl_init_done,
    output logic [2:0]        dbg_state
);

    state_t             state_q;
    logic [WORD_AW-1:0] word_q;
    logic [31:0]        wdata_q;
    logic [3:0]         wstrb_q;
    logic [3:0]         ops_q;
    logic [15:0]        buf_lo_q, buf_lo_d;
    logic [15:0]        buf_hi_q, buf_hi_d;

    logic        ctl_idle;
    logic        cur_half;
    logic        cur_rd;
    logic [3:0]  ops_rest;
    logic        capture;
    logic [1:0]  merge_strb;
    logic [15:0] merged;

    // Address bits outside the word index alias; they are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, mem_addr[31:WORD_AW+2], mem_addr[1:0]};

    assign ctl_idle  = ctl_init_done & ~ctl_busy;
    assign dbg_state = state_q;

    // Current op is the lowest set bit of the remaining op mask.
    assign cur_half = (ops_q[1:0] == 2'b00) ? HALF_HI : HALF_LO;
    assign cur_rd   = (cur_half == HALF_HI) ? ops_q[2] : ops_q[0];
    assign ops_rest = ops_q & (ops_q - 4'd1);

    // Without RMW a partial halfword is written whole from mem_wdata.
    assign merge_strb = (cur_half == HALF_HI) ? wstrb_q[3:2] : wstrb_q[1:0];

    picorv32_sdram32_byte_merge u_merge (
        .old_data_i ((cur_half == HALF_HI) ? buf_hi_q : buf_lo_q),
        .new_data_i ((cur_half == HALF_HI) ? wdata_q[31:16] : wdata_q[15:0]),
        .strb_i     (RMW_EN ? merge_strb : 2'b11),
        .merged_o   (merged)
    );

    // Capture read data into the half buffer; data_valid coinciding with the
    // ack in ISSUE is honoured as well as data arriving during WAIT.
    always_comb begin
        buf_lo_d = buf_lo_q;
        buf_hi_d = buf_hi_q;
        capture  = ctl_data_valid & cur_rd &
                   (((state_q == ST_ISSUE) & ctl_adv & ctl_ack) | (state_q == ST_WAIT));
        if (capture) begin
            if (cur_half == HALF_HI) buf_hi_d = ctl_rdata;
            else                     buf_lo_d = ctl_rdata;
        end
    end

    // Main FSM: accept, plan the op mask, issue/wait per op, respond.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q   <= ST_IDLE;
            word_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            ops_q     <= '0;
            buf_lo_q  <= '0;
            buf_hi_q  <= '0;
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            busy      <= 1'b0;
            ctl_addr  <= '0;
            ctl_adv   <= 1'b0;
            ctl_rwn   <= 1'b1;
            ctl_wdata <= '0;
        end else begin
            buf_lo_q <= buf_lo_d;
            buf_hi_q <= buf_hi_d;
            case (state_q)
                ST_IDLE: begin
                    if (mem_valid && !mem_ready) begin
                        word_q  <= mem_addr[WORD_AW+1:2];
                        wdata_q <= mem_wdata;
                        wstrb_q <= mem_wstrb;
                        busy    <= 1'b1;
                        state_q <= ST_PLAN;
                    end
                end
                ST_PLAN: begin
                    ops_q   <= {half_ops(wstrb_q == 4'b0000, wstrb_q[3:2], RMW_EN),
                                half_ops(wstrb_q == 4'b0000, wstrb_q[1:0], RMW_EN)};
                    state_q <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (!ctl_adv) begin
                        if (ctl_idle) begin
                            ctl_adv  <= 1'b1;
                            ctl_addr <= CTL_AW'({word_q, cur_half});
                            ctl_rwn  <= cur_rd ? OP_RD : OP_WR;
                            if (!cur_rd) ctl_wdata <= merged;
                        end
                    end else if (ctl_ack) begin
                        ctl_adv <= 1'b0;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (ctl_idle && !ctl_adv) begin
                        ops_q <= ops_rest;
                        if (ops_rest == 4'd0) begin
                            mem_ready <= 1'b1;
                            if (wstrb_q == 4'b0000) mem_rdata <= {buf_hi_d, buf_lo_d};
                            state_q <= ST_RESP;
                        end else begin
                            state_q <= ST_ISSUE;
                        end
                    end
                end
                ST_RESP: begin
                    mem_ready <= 1'b0;
                    busy      <= 1'b0;
                    state_q   <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_picorv32_sdram32.sv
// Directed bench for picorv32_sdram32. Two bridges share the CPU-side
// stimulus: u_dut0 with RMW enabled and u_dut1 with RMW disabled. Each has
// its own behavioural controller (ack one cycle after adv, idle two cycles
// after ack) backed by a shared halfword store keyed by instance.
module tb_picorv32_sdram32;

    logic        clk;
    logic        nrst;
    logic        init_done;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;

    logic        mem_valid [2];
    logic        mem_ready [2];
    logic [31:0] mem_rdata [2];
    logic        busy      [2];
    logic [26:0] ctl_addr  [2];
    logic        ctl_adv   [2];
    logic        ctl_rwn   [2];
    logic [15:0] ctl_wdata [2];
    logic [2:0]  dbg_state [2];

    logic        m_ack   [2];
    logic        m_busy  [2];
    logic        m_dv    [2];
    logic [15:0] m_rdata [2];
    logic [15:0] m_hold  [2];
    logic [1:0]  m_cnt   [2];
    logic        m_isrd  [2];

    logic [15:0] hmem [longint];
    logic [43:0] log0 [$];
    logic [43:0] log1 [$];
    logic [43:0] exp_q [$];

    int passed;
    int total;
    int fails;

    // Clock and reset-independent defaults
    initial clk = 1'b0;
    always #5 clk = ~clk;

    picorv32_sdram32 #(.WORD_AW(24), .CTL_AW(27), .RMW_EN(1'b1)) u_dut0 (
        .clk(clk), .nrst(nrst), .mem_valid(mem_valid[0]), .mem_ready(mem_ready[0]),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata[0]), .busy(busy[0]), .ctl_addr(ctl_addr[0]),
        .ctl_adv(ctl_adv[0]), .ctl_rwn(ctl_rwn[0]), .ctl_wdata(ctl_wdata[0]),
        .ctl_ack(m_ack[0]), .ctl_data_valid(m_dv[0]), .ctl_rdata(m_rdata[0]),
        .ctl_busy(m_busy[0]), .ctl_init_done(init_done), .dbg_state(dbg_state[0])
    );

    picorv32_sdram32 #(.WORD_AW(24), .CTL_AW(27), .RMW_EN(1'b0)) u_dut1 (
        .clk(clk), .nrst(nrst), .mem_valid(mem_valid[1]), .mem_ready(mem_ready[1]),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata[1]), .busy(busy[1]), .ctl_addr(ctl_addr[1]),
        .ctl_adv(ctl_adv[1]), .ctl_rwn(ctl_rwn[1]), .ctl_wdata(ctl_wdata[1]),
        .ctl_ack(m_ack[1]), .ctl_data_valid(m_dv[1]), .ctl_rdata(m_rdata[1]),
        .ctl_busy(m_busy[1]), .ctl_init_done(init_done), .dbg_state(dbg_state[1])
    );

    function automatic longint key(input int inst, input logic [26:0] a);
        return (longint'(inst) << 32) | longint'(a);
    endfunction

    function automatic logic [15:0] mrd(input longint k);
        return hmem.exists(k) ? hmem[k] : 16'h0000;
    endfunction

    function automatic logic [43:0] ent(input logic rwn, input logic [26:0] a, input logic [15:0] d);
        return {rwn, a, rwn ? 16'h0000 : d};
    endfunction

    // Behavioural controller per instance; logs every accepted command.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!nrst) begin
                m_ack[i]   <= 1'b0;
                m_busy[i]  <= 1'b0;
                m_dv[i]    <= 1'b0;
                m_rdata[i] <= 16'h0000;
                m_hold[i]  <= 16'h0000;
                m_cnt[i]   <= 2'd0;
                m_isrd[i]  <= 1'b0;
            end else begin
                m_ack[i] <= 1'b0;
                m_dv[i]  <= 1'b0;
                if (ctl_adv[i] && !m_ack[i] && !m_busy[i]) begin
                    m_ack[i]  <= 1'b1;
                    m_busy[i] <= 1'b1;
                    m_cnt[i]  <= 2'd2;
                    m_isrd[i] <= ctl_rwn[i];
                    if (ctl_rwn[i]) m_hold[i] <= mrd(key(i, ctl_addr[i]));
                    else hmem[key(i, ctl_addr[i])] = ctl_wdata[i];
                    if (i == 0) log0.push_back(ent(ctl_rwn[i], ctl_addr[i], ctl_wdata[i]));
                    else        log1.push_back(ent(ctl_rwn[i], ctl_addr[i], ctl_wdata[i]));
                end else if (m_busy[i]) begin
                    m_cnt[i] <= m_cnt[i] - 2'd1;
                    if (m_cnt[i] == 2'd1) begin
                        m_busy[i]  <= 1'b0;
                        m_dv[i]    <= m_isrd[i];
                        m_rdata[i] <= m_hold[i];
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: compare the controller command log with exp_q, then clear.
    task automatic check_log(input int inst, input string tag);
        logic [43:0] got [$];
        if (inst == 0) got = log0;
        else           got = log1;
        chk({tag, "_nops"}, 64'(got.size()), 64'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++) begin
            chk($sformatf("%s_op%0d", tag, k), (k < got.size()) ? 64'(got[k]) : 64'hdead, 64'(exp_q[k]));
        end
        exp_q.delete();
        log0.delete();
        log1.delete();
    endtask

    // Driver: one bus access, bounded wait for mem_ready, then pulse checks.
    task automatic access(input int inst, input string tag, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s,
                          output logic [31:0] rd, output int cyc);
        mem_addr  = a;
        mem_wdata = d;
        mem_wstrb = s;
        mem_valid[inst] = 1'b1;
        cyc = 0;
        rd  = 32'h0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            cyc++;
            if (mem_ready[inst]) break;
        end
        rd = mem_rdata[inst];
        chk({tag, "_ready"}, 64'(mem_ready[inst]), 64'd1);
        chk({tag, "_busy_in_pulse"}, 64'(busy[inst]), 64'd1);
        mem_valid[inst] = 1'b0;
        @(negedge clk);
        chk({tag, "_pulse_end"}, 64'(mem_ready[inst]), 64'd0);
        chk({tag, "_busy_end"}, 64'(busy[inst]), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          cyc;
        int          adv_seen;

        passed = 0;
        total  = 0;
        fails  = 0;
        nrst      = 1'b0;
        init_done = 1'b0;
        mem_valid[0] = 1'b0;
        mem_valid[1] = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_wstrb = 4'h0;

        // Test 1: reset with init_done low and a read pending
        hmem[key(0, 27'h20)] = 16'hBEEF;
        hmem[key(0, 27'h21)] = 16'hDEAD;
        mem_addr = 32'h0000_0040;
        mem_valid[0] = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(mem_ready[0]), 64'd0);
        chk("rst_adv", 64'(ctl_adv[0]), 64'd0);
        chk("rst_busy", 64'(busy[0]), 64'd0);
        chk("rst_rdata", 64'(mem_rdata[0]), 64'd0);
        chk("rst_addr", 64'(ctl_addr[0]), 64'd0);
        chk("rst_wdata", 64'(ctl_wdata[0]), 64'd0);
        chk("rst_rwn", 64'(ctl_rwn[0]), 64'd1);
        chk("rst_state", 64'(dbg_state[0]), 64'd0);
        nrst = 1'b1;
        adv_seen = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (ctl_adv[0]) adv_seen++;
        end
        chk("t1_no_adv_before_init", 64'(adv_seen), 64'd0);
        chk("t1_busy_while_waiting", 64'(busy[0]), 64'd1);
        init_done = 1'b1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (mem_ready[0]) break;
        end
        chk("t1_ready", 64'(mem_ready[0]), 64'd1);
        chk("t1_rdata", 64'(mem_rdata[0]), 64'hDEADBEEF);
        mem_valid[0] = 1'b0;
        @(negedge clk);
        chk("t1_pulse_end", 64'(mem_ready[0]), 64'd0);
        exp_q.push_back(ent(1'b1, 27'h20, 16'h0));
        exp_q.push_back(ent(1'b1, 27'h21, 16'h0));
        check_log(0, "t1_log");

        // Test 2: full-word write then read back
        access(0, "t2_wr", 32'h0000_0100, 32'h12345678, 4'b1111, rd, cyc);
        chk("t2_wr_rdata_kept", 64'(rd), 64'hDEADBEEF);
        chk("t2_wr_latency", 64'(cyc), 64'd12);
        exp_q.push_back(ent(1'b0, 27'h80, 16'h5678));
        exp_q.push_back(ent(1'b0, 27'h81, 16'h1234));
        check_log(0, "t2_wr_log");
        access(0, "t2_rd", 32'h0000_0100, 32'h0, 4'b0000, rd, cyc);
        chk("t2_rd_data", 64'(rd), 64'h12345678);
        chk("t2_rd_latency", 64'(cyc), 64'd12);
        exp_q.push_back(ent(1'b1, 27'h80, 16'h0));
        exp_q.push_back(ent(1'b1, 27'h81, 16'h0));
        check_log(0, "t2_rd_log");

        // Test 3: single-byte write with RMW
        hmem[key(0, 27'h100)] = 16'hCCDD;
        hmem[key(0, 27'h101)] = 16'hAABB;
        access(0, "t3_wr", 32'h0000_0200, 32'h0000_1100, 4'b0010, rd, cyc);
        chk("t3_wr_rdata_kept", 64'(rd), 64'h12345678);
        chk("t3_wr_latency", 64'(cyc), 64'd12);
        exp_q.push_back(ent(1'b1, 27'h100, 16'h0));
        exp_q.push_back(ent(1'b0, 27'h100, 16'h11DD));
        check_log(0, "t3_wr_log");
        access(0, "t3_rd", 32'h0000_0200, 32'h0, 4'b0000, rd, cyc);
        chk("t3_rd_data", 64'(rd), 64'hAABB11DD);
        log0.delete();

        // Test 4: upper-halfword write, single WR with no RD
        hmem[key(0, 27'h180)] = 16'h5555;
        hmem[key(0, 27'h181)] = 16'h6666;
        access(0, "t4_wr", 32'h0000_0300, 32'hCAFE0000, 4'b1100, rd, cyc);
        chk("t4_wr_rdata_kept", 64'(rd), 64'hAABB11DD);
        chk("t4_wr_latency", 64'(cyc), 64'd7);
        exp_q.push_back(ent(1'b0, 27'h181, 16'hCAFE));
        check_log(0, "t4_wr_log");
        chk("t4_lo_untouched", 64'(mrd(key(0, 27'h180))), 64'h5555);
        access(0, "t4_rd", 32'h0000_0300, 32'h0, 4'b0000, rd, cyc);
        chk("t4_rd_data", 64'(rd), 64'hCAFE5555);
        log0.delete();

        // Test 5: single-byte write with RMW disabled
        hmem[key(1, 27'h100)] = 16'hCCDD;
        hmem[key(1, 27'h101)] = 16'hAABB;
        access(1, "t5_wr", 32'h0000_0200, 32'h0000_1100, 4'b0010, rd, cyc);
        chk("t5_wr_rdata_kept", 64'(rd), 64'h0);
        chk("t5_wr_latency", 64'(cyc), 64'd7);
        exp_q.push_back(ent(1'b0, 27'h100, 16'h1100));
        check_log(1, "t5_wr_log");
        chk("t5_mem_lo", 64'(mrd(key(1, 27'h100))), 64'h1100);
        chk("t5_mem_hi", 64'(mrd(key(1, 27'h101))), 64'hAABB);

        // Test 6: reset during WAIT of a 4-op write, then a normal access
        mem_addr  = 32'h0000_0400;
        mem_wdata = 32'h11223344;
        mem_wstrb = 4'b0101;
        mem_valid[0] = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (log0.size() >= 2) break;
        end
        chk("t6_two_ops_issued", 64'(log0.size()), 64'd2);
        @(negedge clk);
        mem_valid[0] = 1'b0;
        chk("t6_in_wait", 64'(dbg_state[0]), 64'd3);
        nrst = 1'b0;
        @(negedge clk);
        chk("t6_rst_adv", 64'(ctl_adv[0]), 64'd0);
        chk("t6_rst_ready", 64'(mem_ready[0]), 64'd0);
        chk("t6_rst_busy", 64'(busy[0]), 64'd0);
        chk("t6_rst_state", 64'(dbg_state[0]), 64'd0);
        nrst = 1'b1;
        adv_seen = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (mem_ready[0] || ctl_adv[0]) adv_seen++;
        end
        chk("t6_quiet_after_rst", 64'(adv_seen), 64'd0);
        log0.delete();
        access(0, "t6_wr", 32'h0000_0400, 32'h0BADF00D, 4'b1111, rd, cyc);
        chk("t6_wr_latency", 64'(cyc), 64'd12);
        exp_q.push_back(ent(1'b0, 27'h200, 16'hF00D));
        exp_q.push_back(ent(1'b0, 27'h201, 16'h0BAD));
        check_log(0, "t6_wr_log");
        access(0, "t6_rd", 32'h0000_0400, 32'h0, 4'b0000, rd, cyc);
        chk("t6_rd_data", 64'(rd), 64'h0BADF00D);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
